// File: rtl/sblk_pkg.sv
// Shared constants and types for the sblk activation path: widths, packed act pair, feeder FSM states
// and the burst-length helper used by act_feeder.
package sblk_pkg;
   localparam int N_TILE      = 4;
   localparam int WID_ACT     = 16;
   localparam int WID_ACTADDR = 6;
   localparam int WID_INST_TN = 3;
   localparam int WID_INST_TP = 2;
   localparam int ACT_DEPTH   = 2**WID_ACTADDR;
   localparam int WID_CNT     = WID_ACTADDR + 1;
   localparam int WID_LEN     = $clog2(N_TILE + 1) + WID_INST_TN + WID_INST_TP;

   typedef logic [2*WID_ACT-1:0] act2_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST
   } feed_state_e;

   // Wide enough for N_TILE * max(tn) * max(tp), so the product never wraps.
   function automatic logic [WID_LEN-1:0] calc_burst_len(input logic [WID_INST_TN-1:0] tn,
                                                         input logic [WID_INST_TP-1:0] tp);
      return WID_LEN'(N_TILE) * WID_LEN'(tn) * WID_LEN'(tp);
   endfunction
endpackage

// File: rtl/act_pair_fifo.sv
// Packs single activations into {later, earlier} pairs and buffers them in a synchronous-read FIFO.
// rd_data is registered and returns to zero on any cycle without a pop.
module act_pair_fifo
   import sblk_pkg::*;
(
   input  logic                   clk_l,
   input  logic                   rst,
   input  logic                   wr_vld,
   input  logic [WID_ACT-1:0]     wr_data,
   output logic                   wr_rdy,
   input  logic                   pop,
   output logic [2*WID_ACT-1:0]   rd_data,
   output logic [WID_CNT-1:0]     count,
   output logic                   empty
);
   act2_t                  mem [ACT_DEPTH];
   logic [WID_ACTADDR-1:0] wr_ptr;
   logic [WID_ACTADDR-1:0] rd_ptr;
   logic                   half_vld;
   logic [WID_ACT-1:0]     half_data;
   logic                   full;
   logic                   accept;
   logic                   push;

   assign full   = (count == WID_CNT'(ACT_DEPTH));
   assign empty  = (count == '0);
   // A lone half act can always be taken; only completing a pair needs FIFO room.
   assign wr_rdy = !rst && !(half_vld && full);
   assign accept = wr_vld && wr_rdy;
   assign push   = accept && half_vld;

   always_ff @(posedge clk_l or posedge rst) begin
      if (rst) begin
         half_vld <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
      end else begin
         if (accept)
            half_vld <= !half_vld;
         if (push)
            wr_ptr <= wr_ptr + WID_ACTADDR'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + WID_ACTADDR'(1);
            rd_data <= mem[rd_ptr];
         end else begin
            rd_data <= '0;
         end
         case ({push, pop})
            2'b10:   count <= count + WID_CNT'(1);
            2'b01:   count <= count - WID_CNT'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_l) begin
      if (accept && !half_vld)
         half_data <= wr_data;
      if (push)
         mem[wr_ptr] <= {wr_data, half_data};
   end
endmodule

// File: rtl/act_feeder.sv
// Activation feeder for sblk: buffers packed act pairs and answers each request with one gap-free burst
// of N_TILE*tn*tp words. Optional ACT_FEEDER_STALL_CNT_EN adds stall_cnt (cycles spent waiting for data).
module act_feeder
   import sblk_pkg::*;
(
   input  logic                     clk_l,
   input  logic                     rst,
   input  logic                     cfg_en,
   input  logic [WID_INST_TN-1:0]   cfg_tn,
   input  logic [WID_INST_TP-1:0]   cfg_tp,
   input  logic                     wr_vld,
   input  logic [WID_ACT-1:0]       wr_data,
   output logic                     wr_rdy,
   input  logic                     act_data_in_req,
   output logic                     act_data_in_vld,
   output logic [2*WID_ACT-1:0]     act_data_in,
   output logic                     status_feed,
`ifdef ACT_FEEDER_STALL_CNT_EN
   output logic [31:0]              stall_cnt,
`endif
   output logic                     cfg_err
);
   feed_state_e              state;
   logic                     armed;
   logic [WID_INST_TN-1:0]   tn_q;
   logic [WID_INST_TP-1:0]   tp_q;
   logic [WID_LEN-1:0]       len_req;
   logic                     len_bad;
   logic [WID_CNT-1:0]       burst_len_q;
   logic [WID_CNT-1:0]       beats_left;
   logic [WID_CNT-1:0]       fifo_count;
   logic                     fifo_empty;
   logic                     enough;
   logic                     pop;

   assign len_req = calc_burst_len(tn_q, tp_q);
   assign len_bad = (len_req == '0) || (int'(len_req) > ACT_DEPTH);
   assign enough  = (fifo_count >= burst_len_q);
   // First pop happens on the WAIT->BURST edge so the beat lands in the first BURST cycle.
   assign pop     = !fifo_empty && (((state == WAIT) && enough) ||
                                    ((state == BURST) && (beats_left != '0)));

   act_pair_fifo u_fifo (
      .clk_l   (clk_l),
      .rst     (rst),
      .wr_vld  (wr_vld),
      .wr_data (wr_data),
      .wr_rdy  (wr_rdy),
      .pop     (pop),
      .rd_data (act_data_in),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk_l or posedge rst) begin
      if (rst) begin
         tn_q <= '0;
         tp_q <= '0;
      end else if (cfg_en) begin
         tn_q <= cfg_tn;
         tp_q <= cfg_tp;
      end
   end

   always_ff @(posedge clk_l or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         armed           <= 1'b1;
         status_feed     <= 1'b0;
         cfg_err         <= 1'b0;
         burst_len_q     <= '0;
         beats_left      <= '0;
         act_data_in_vld <= 1'b0;
      end else begin
         act_data_in_vld <= pop;
         if (!act_data_in_req)
            armed <= 1'b1;
         case (state)
            IDLE: begin
               status_feed <= 1'b0;
               if (act_data_in_req && armed) begin
                  armed       <= 1'b0;
                  status_feed <= 1'b1;
                  if (len_bad) begin
                     cfg_err <= 1'b1;
                  end else begin
                     burst_len_q <= WID_CNT'(len_req);
                     state       <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (enough) begin
                  beats_left <= burst_len_q - WID_CNT'(1);
                  state      <= BURST;
               end
            end
            BURST: begin
               if (beats_left == '0) begin
                  state       <= IDLE;
                  status_feed <= 1'b0;
               end else begin
                  beats_left <= beats_left - WID_CNT'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ACT_FEEDER_STALL_CNT_EN
   always_ff @(posedge clk_l or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if ((state == WAIT) && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_act_feeder.sv
// Scoreboard bench for act_feeder: accepted acts are paired into an expected word queue, accepted
// requests grant beat allowances, and a negedge monitor checks every beat and every burst length.
module tb_act_feeder;
   localparam int WA = 16;

   logic            clk_l = 1'b0;
   logic            rst = 1'b1;
   logic            cfg_en = 1'b0;
   logic [2:0]      cfg_tn = '0;
   logic [1:0]      cfg_tp = '0;
   logic            wr_vld = 1'b0;
   logic [WA-1:0]   wr_data = '0;
   logic            act_data_in_req = 1'b0;
   logic            wr_rdy;
   logic            act_data_in_vld;
   logic [2*WA-1:0] act_data_in;
   logic            status_feed;
   logic            cfg_err;
`ifdef ACT_FEEDER_STALL_CNT_EN
   logic [31:0]     stall_cnt;
   logic [31:0]     stall_s0;
`endif

   always #5 clk_l = ~clk_l;

   act_feeder dut (
      .clk_l           (clk_l),
      .rst             (rst),
      .cfg_en          (cfg_en),
      .cfg_tn          (cfg_tn),
      .cfg_tp          (cfg_tp),
      .wr_vld          (wr_vld),
      .wr_data         (wr_data),
      .wr_rdy          (wr_rdy),
      .act_data_in_req (act_data_in_req),
      .act_data_in_vld (act_data_in_vld),
      .act_data_in     (act_data_in),
      .status_feed     (status_feed),
`ifdef ACT_FEEDER_STALL_CNT_EN
      .stall_cnt       (stall_cnt),
`endif
      .cfg_err         (cfg_err)
   );

   int              vectors = 0;
   int              miscompares = 0;
   logic [2*WA-1:0] word_q[$];
   int              burst_q[$];
   int              allow = 0;
   int              run_len = 0;
   logic            m_half_vld = 1'b0;
   logic [WA-1:0]   m_half = '0;
   int              m_tn = 0;
   int              m_tp = 0;
   int              n_wait = 0;
   logic [2*WA-1:0] exp_w;

   task automatic chkw(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      chkw(name, {63'd0, got}, {63'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk_l);
      #1;
   endtask

   task automatic set_cfg(input int tn, input int tp);
      cfg_en = 1'b1;
      cfg_tn = 3'(tn);
      cfg_tp = 2'(tp);
      @(posedge clk_l);
      m_tn = tn;
      m_tp = tp;
      #1;
      cfg_en = 1'b0;
   endtask

   task automatic write_act(input logic [WA-1:0] d);
      bit done = 0;
      wr_vld  = 1'b1;
      wr_data = d;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk_l);
         if (wr_rdy) begin
            @(posedge clk_l);
            if (m_half_vld) begin
               word_q.push_back({d, m_half});
               m_half_vld = 1'b0;
            end else begin
               m_half     = d;
               m_half_vld = 1'b1;
            end
            done = 1;
            #1;
         end
      end
      if (!done) chk1("write_timeout", 1'b1, 1'b0);
      wr_vld = 1'b0;
   endtask

   task automatic write_rand(input int n);
      for (int i = 0; i < n; i++) write_act(WA'($urandom));
   endtask

   // Request length follows N_TILE*tn*tp; zero or more than the 64-word FIFO is refused.
   task automatic model_accept();
      int len;
      len = 4 * m_tn * m_tp;
      if (len != 0 && len <= 64) begin
         burst_q.push_back(len);
         allow += len;
      end
   endtask

   task automatic do_req();
      act_data_in_req = 1'b1;
      @(posedge clk_l);
      model_accept();
      #1;
      act_data_in_req = 1'b0;
   endtask

   task automatic wait_vld(input string name);
      bit seen = 0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk_l);
         if (act_data_in_vld) seen = 1;
      end
      if (!seen) chk1({name, "_timeout"}, 1'b1, 1'b0);
   endtask

   task automatic wait_idle(input string name);
      bit   seen = 0;
      logic prev_vld = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk_l);
         if (!status_feed) begin
            seen = 1;
            chk1({name, "_end_vld"}, act_data_in_vld, 1'b0);
            chk1({name, "_status_through_last"}, prev_vld, 1'b1);
         end
         prev_vld = act_data_in_vld;
      end
      if (!seen) chk1({name, "_timeout"}, 1'b1, 1'b0);
      tick();
   endtask

   always @(negedge clk_l) begin
      if (rst) begin
         run_len = 0;
      end else if (act_data_in_vld) begin
         if (allow == 0 || word_q.size() == 0) begin
            chk1("unexpected_beat", 1'b1, 1'b0);
         end else begin
            exp_w = word_q.pop_front();
            allow--;
            chkw("beat", 64'(act_data_in), 64'(exp_w));
         end
         run_len++;
      end else begin
         chkw("idle_data", 64'(act_data_in), 64'd0);
         if (run_len > 0) begin
            if (burst_q.size() == 0) chk1("burst_unexpected", 1'b1, 1'b0);
            else chkw("burst_len", 64'(run_len), 64'(burst_q.pop_front()));
            run_len = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      @(negedge clk_l);
      chk1("rst_wr_rdy", wr_rdy, 1'b0);
      chk1("rst_vld", act_data_in_vld, 1'b0);
      chkw("rst_data", 64'(act_data_in), 64'd0);
      chk1("rst_status", status_feed, 1'b0);
      chk1("rst_cfg_err", cfg_err, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk_l);
      chk1("post_rst_wr_rdy", wr_rdy, 1'b1);
      tick();

      // 1: prebuffered burst, latency and status
      set_cfg(2, 2);
      for (int i = 0; i < 32; i++) write_act(WA'(i));
      do_req();
      @(negedge clk_l);
      chk1("t1_lat_vld0", act_data_in_vld, 1'b0);
      chk1("t1_status_acc", status_feed, 1'b1);
      @(negedge clk_l);
      chk1("t1_first_vld", act_data_in_vld, 1'b1);
      chkw("t1_first_beat", 64'(act_data_in), 64'h0000_0001_0000);
      repeat (7) @(negedge clk_l);
      chk1("t1_status_mid", status_feed, 1'b1);
      wait_idle("t1");

      // 2: request waits for data
`ifdef ACT_FEEDER_STALL_CNT_EN
      stall_s0 = stall_cnt;
`endif
      write_rand(10);
      do_req();
      fork
         begin
            repeat (12) tick();
            chk1("t2_wait_status", status_feed, 1'b1);
            write_rand(22);
         end
         begin
            bit seen = 0;
            n_wait = 0;
            for (int i = 0; i < 600 && !seen; i++) begin
               @(negedge clk_l);
               if (act_data_in_vld) seen = 1;
               else n_wait++;
            end
            if (!seen) chk1("t2_burst_timeout", 1'b1, 1'b0);
         end
      join
      wait_idle("t2");
`ifdef ACT_FEEDER_STALL_CNT_EN
      chkw("t2_stall_cnt", 64'(stall_cnt - stall_s0), 64'(n_wait));
`endif

      // 3: refused lengths leave the FIFO alone
      write_rand(32);
      chk1("t3_err_before", cfg_err, 1'b0);
      set_cfg(7, 3);
      do_req();
      @(negedge clk_l);
      chk1("t3_big_status1", status_feed, 1'b1);
      @(negedge clk_l);
      chk1("t3_big_status0", status_feed, 1'b0);
      chk1("t3_big_err", cfg_err, 1'b1);
      tick();
      set_cfg(0, 2);
      do_req();
      @(negedge clk_l);
      chk1("t3_zero_status1", status_feed, 1'b1);
      @(negedge clk_l);
      chk1("t3_zero_status0", status_feed, 1'b0);
      chk1("t3_err_sticky", cfg_err, 1'b1);
      repeat (4) tick();
      set_cfg(2, 2);
      do_req();
      wait_idle("t3");

      // 4: full FIFO, back-pressure, wrap-around with concurrent traffic
      write_rand(129);
      @(negedge clk_l);
      chk1("t4_full_rdy", wr_rdy, 1'b0);
      tick();
      fork
         write_rand(64);
         begin
            for (int b = 0; b < 3; b++) begin
               do_req();
               wait_vld("t4_burst");
               if (b == 0) chk1("t4_rdy_during_pop", wr_rdy, 1'b1);
               wait_idle("t4");
            end
         end
      join

      // 5: held request and mid-burst reconfiguration
      act_data_in_req = 1'b1;
      @(posedge clk_l);
      model_accept();
      #1;
      repeat (4) tick();
      set_cfg(1, 1);
      repeat (35) tick();
      act_data_in_req = 1'b0;
      @(negedge clk_l);
      chk1("t5_no_second", status_feed, 1'b0);
      tick();
      do_req();
      wait_idle("t5");

      // 6: reset during a burst
      set_cfg(2, 2);
      do_req();
      wait_vld("t6_burst");
      repeat (3) tick();
      rst = 1'b1;
      word_q.delete();
      burst_q.delete();
      allow      = 0;
      m_half_vld = 1'b0;
      m_tn       = 0;
      m_tp       = 0;
      #1;
      chk1("t6_rst_vld", act_data_in_vld, 1'b0);
      chkw("t6_rst_data", 64'(act_data_in), 64'd0);
      chk1("t6_rst_status", status_feed, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk_l);
      chk1("t6_wr_rdy", wr_rdy, 1'b1);
      chk1("t6_err_clr", cfg_err, 1'b0);
      tick();
      do_req();
      @(negedge clk_l);
      chk1("t6_armed_status", status_feed, 1'b1);
      @(negedge clk_l);
      chk1("t6_cfg_cleared_err", cfg_err, 1'b1);
      tick();
      set_cfg(1, 1);
      write_rand(6);
      do_req();
      repeat (10) tick();
      @(negedge clk_l);
      chk1("t6_empty_wait", status_feed, 1'b1);
      tick();
      write_rand(2);
      wait_idle("t6");

      repeat (3) tick();
      chkw("end_allow", 64'(allow), 64'd0);
      chkw("end_bursts", 64'(burst_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
